// File: rtl/updn_counter_rpt_pkg.sv
// Shared types and board defaults for the push-button up/down counter.
package updn_counter_rpt_pkg;

  // Per-cycle step request seen by the count register
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DN   = 2'b10
  } step_e;

  // Auto-repeat state per button
  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rpt_state_e;

  // Defaults for the 50 MHz demo board
  localparam int unsigned DEB_CYC_DEF = 500000;    // 10 ms
  localparam int unsigned RPT_DLY_DEF = 25000000;  // 0.5 s
  localparam int unsigned RPT_PER_DEF = 5000000;   // 0.1 s

  // Coincident up and down steps cancel out
  function automatic step_e step_decode(input logic up, input logic dn);
    case ({up, dn})
      2'b10:   return STEP_UP;
      2'b01:   return STEP_DN;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/updn_counter_rpt_push_conditioner.sv
// One push button: 2-flop synchroniser, debouncer, press detect and auto-repeat.
module push_conditioner
  import updn_counter_rpt_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned RPT_DLY = RPT_DLY_DEF,
  parameter int unsigned RPT_PER = RPT_PER_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Push_n,
  output logic o_Level,
  output logic o_Step
);

  // Two extra cycles cover the synchroniser flops still holding their reset value
  localparam int unsigned ARM_CYC = DEB_CYC + 2;
  localparam int unsigned DEB_W   = $clog2(ARM_CYC + 1);
  localparam int unsigned TMR_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  logic             sync1_q, sync2_q, level_q, armed_q, step_q;
  logic [DEB_W-1:0] deb_cnt_q, arm_cnt_q;
  logic [TMR_W-1:0] tmr_q;
  rpt_state_e       state_q;
  logic             accept_c, press_c, rel_c;

  // Level change is accepted on the DEB_CYC-th consecutive differing sample
  assign accept_c = (sync2_q != level_q) && (deb_cnt_q == DEB_W'(DEB_CYC - 1));
  // A button held through reset stays unarmed until seen released
  assign press_c  = accept_c && !sync2_q && armed_q;
  assign rel_c    = accept_c && sync2_q;

  // Synchronise, debounce and arm after a confirmed release
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b1;
      deb_cnt_q <= '0;
      arm_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q <= i_Push_n;
      sync2_q <= sync1_q;
      if (sync2_q != level_q) begin
        if (accept_c) begin
          level_q   <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
      if (!armed_q) begin
        if (!sync2_q) begin
          arm_cnt_q <= '0;
        end else if (arm_cnt_q == DEB_W'(ARM_CYC - 1)) begin
          armed_q <= 1'b1;
        end else begin
          arm_cnt_q <= arm_cnt_q + DEB_W'(1);
        end
      end
    end
  end

  // Repeat FSM: step on press, after RPT_DLY, then every RPT_PER while held
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (rel_c) begin
        state_q <= StIdle;
        tmr_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            tmr_q <= '0;
            if (press_c) begin
              step_q  <= 1'b1;
              state_q <= StDelay;
            end
          end
          StDelay: begin
            if (tmr_q == TMR_W'(RPT_DLY - 1)) begin
              step_q  <= 1'b1;
              tmr_q   <= '0;
              state_q <= StRepeat;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          StRepeat: begin
            if (tmr_q == TMR_W'(RPT_PER - 1)) begin
              step_q <= 1'b1;
              tmr_q  <= '0;
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            tmr_q   <= '0;
          end
        endcase
      end
    end
  end

  assign o_Level = level_q;
  assign o_Step  = step_q;

endmodule

// File: rtl/updn_counter_rpt.sv
// Modulo up/down counter driven by two conditioned push buttons.
module updn_counter_rpt
  import updn_counter_rpt_pkg::*;
#(
  parameter int unsigned MOD_N   = 16,
  parameter int unsigned CNT_W   = $clog2(MOD_N),
  parameter int unsigned SAT     = 0,
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned RPT_DLY = RPT_DLY_DEF,
  parameter int unsigned RPT_PER = RPT_PER_DEF,
  parameter int unsigned LED_W   = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [1:0]       i_Push,
  output logic [CNT_W-1:0] o_Cnt,
  output logic [LED_W-1:0] o_LED,
  output logic             o_Wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD_N - 1);

  logic             up_step, dn_step, up_level, dn_level;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap_q;
  step_e            step;

  push_conditioner #(
    .DEB_CYC (DEB_CYC),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) u_up (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Push_n (i_Push[1]),
    .o_Level  (up_level),
    .o_Step   (up_step)
  );

  push_conditioner #(
    .DEB_CYC (DEB_CYC),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) u_dn (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Push_n (i_Push[0]),
    .o_Level  (dn_level),
    .o_Step   (dn_step)
  );

  // Debounced levels are only kept for probing
  logic unused_levels;
  assign unused_levels = up_level ^ dn_level;

  assign step = step_decode(up_step, dn_step);

  // Count register: modulo MOD_N wrap or saturate, flagging the limit step
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (step)
        STEP_UP: begin
          if (cnt_q == CNT_MAX) begin
            wrap_q <= 1'b1;
            if (SAT == 0) cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STEP_DN: begin
          if (cnt_q == '0) begin
            wrap_q <= 1'b1;
            if (SAT == 0) cnt_q <= CNT_MAX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Cnt  = cnt_q;
  assign o_Wrap = wrap_q;

  if (LED_W <= CNT_W) begin : g_led_slice
    assign o_LED = cnt_q[LED_W-1:0];
  end else begin : g_led_pad
    assign o_LED = {{(LED_W - CNT_W){1'b0}}, cnt_q};
  end

endmodule

// File: tb/tb_updn_counter_rpt.sv
// Bench for updn_counter_rpt: wrap (SAT=0) and saturate (SAT=1) builds side by side.
module tb_updn_counter_rpt;

  localparam int MOD_N = 10;
  localparam int DEB   = 4;
  localparam int DLY   = 20;
  localparam int PER   = 5;
  localparam int CW    = 4;
  localparam int LW    = 4;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic [1:0]    push = 2'b11;
  logic [CW-1:0] cnt0, cnt1;
  logic [LW-1:0] led0, led1;
  logic          wrap0, wrap1;

  int n_cmp = 0;
  int n_bad = 0;
  int m0 = 0;  // model count, wrap build
  int m1 = 0;  // model count, saturate build

  logic [1:0] pat_q[$];
  bit         rst_q[$];
  int         oc0[$], oc1[$], ol0[$], ol1[$];
  bit         ow0[$], ow1[$];

  always #5 clk = ~clk;

  updn_counter_rpt #(
    .MOD_N (MOD_N), .SAT (0), .DEB_CYC (DEB), .RPT_DLY (DLY), .RPT_PER (PER), .LED_W (LW)
  ) dut0 (
    .i_Clk (clk), .i_Rst (rst), .i_Push (push), .o_Cnt (cnt0), .o_LED (led0), .o_Wrap (wrap0)
  );

  updn_counter_rpt #(
    .MOD_N (MOD_N), .SAT (1), .DEB_CYC (DEB), .RPT_DLY (DLY), .RPT_PER (PER), .LED_W (LW)
  ) dut1 (
    .i_Clk (clk), .i_Rst (rst), .i_Push (push), .o_Cnt (cnt1), .o_LED (led1), .o_Wrap (wrap1)
  );

  // Reference: a clean press whose first low sample is pattern index e_idx, held for hold
  // samples, steps at offsets 0, DLY, DLY+PER, ... (< hold), each landing DEB+2 edges later.
  function automatic void model_at(input int start, input int dir, input int e_idx,
                                   input int hold, input int n, input bit sat,
                                   output int c, output bit w);
    int  at;
    bit  lim;
    c = start;
    w = 1'b0;
    if (dir == 0) return;
    for (int t = 0; t < hold; t = (t == 0) ? DLY : t + PER) begin
      at = e_idx + DEB + 2 + t;
      if (at > n) break;
      lim = (dir > 0) ? (c == MOD_N - 1) : (c == 0);
      w   = lim && (at == n);
      if (!lim) c = c + dir;
      else if (!sat) c = (dir > 0) ? 0 : MOD_N - 1;
    end
  endfunction

  task automatic add_seg(input logic [1:0] v, input int len, input bit r);
    for (int i = 0; i < len; i++) begin
      pat_q.push_back(v);
      rst_q.push_back(r);
    end
  endtask

  // Drive one pattern entry per cycle and record outputs just after each edge
  task automatic run_pattern();
    oc0.delete(); oc1.delete(); ol0.delete(); ol1.delete(); ow0.delete(); ow1.delete();
    @(negedge clk);
    for (int n = 0; n < pat_q.size(); n++) begin
      push = pat_q[n];
      rst  = rst_q[n];
      @(posedge clk);
      @(negedge clk);
      oc0.push_back(int'(cnt0)); oc1.push_back(int'(cnt1));
      ol0.push_back(int'(led0)); ol1.push_back(int'(led1));
      ow0.push_back(wrap0);      ow1.push_back(wrap1);
    end
    push = 2'b11;
    rst  = 1'b0;
    pat_q.delete();
    rst_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    m0 = 0;
    m1 = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cnt0, led0, wrap0, cnt1, led1, wrap1} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: cnt0=%0d led0=%0d wrap0=%0b cnt1=%0d led1=%0d wrap1=%0b, want all 0",
               cnt0, led0, wrap0, cnt1, led1, wrap1);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cnt0, wrap0, cnt1, wrap1} !== '0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d: cnt0=%0d wrap0=%0b cnt1=%0d wrap1=%0b, want 0",
                 i, cnt0, wrap0, cnt1, wrap1);
      end
    end
  endtask

  task automatic test_clean_press();
    int e0, e1; bit x0, x1;
    int hold = DEB + 3;
    add_seg(2'b01, hold, 1'b0);
    add_seg(2'b11, 30, 1'b0);
    run_pattern();
    for (int n = 0; n < oc0.size(); n++) begin
      model_at(m0, 1, 0, hold, n, 1'b0, e0, x0);
      model_at(m1, 1, 0, hold, n, 1'b1, e1, x1);
      n_cmp += 2;
      if (oc0[n] !== e0 || ol0[n] !== e0 || ow0[n] !== x0) begin
        n_bad++;
        $display("FAIL clean_sat0 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc0[n], ol0[n], ow0[n], e0, x0);
      end
      if (oc1[n] !== e1 || ol1[n] !== e1 || ow1[n] !== x1) begin
        n_bad++;
        $display("FAIL clean_sat1 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc1[n], ol1[n], ow1[n], e1, x1);
      end
    end
    m0 = e0;
    m1 = e1;
  endtask

  task automatic test_bounce();
    int e0, e1, s, hold; bit x0, x1;
    int nb = 1 + int'($urandom % 3);
    for (int b = 0; b < nb; b++) begin
      add_seg(2'b01, int'($urandom_range(1, DEB - 1)), 1'b0);
      add_seg(2'b11, int'($urandom_range(1, DEB - 1)), 1'b0);
    end
    s    = pat_q.size();
    hold = DEB + 2 + int'($urandom % 3);
    add_seg(2'b01, hold, 1'b0);
    add_seg(2'b11, 30, 1'b0);
    run_pattern();
    for (int n = 0; n < oc0.size(); n++) begin
      model_at(m0, 1, s, hold, n, 1'b0, e0, x0);
      model_at(m1, 1, s, hold, n, 1'b1, e1, x1);
      n_cmp += 2;
      if (oc0[n] !== e0 || ol0[n] !== e0 || ow0[n] !== x0) begin
        n_bad++;
        $display("FAIL bounce_sat0 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc0[n], ol0[n], ow0[n], e0, x0);
      end
      if (oc1[n] !== e1 || ol1[n] !== e1 || ow1[n] !== x1) begin
        n_bad++;
        $display("FAIL bounce_sat1 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc1[n], ol1[n], ow1[n], e1, x1);
      end
    end
    m0 = e0;
    m1 = e1;
  endtask

  task automatic test_hold_repeat();
    int e0, e1, w0n, w1n; bit x0, x1;
    int hold = int'($urandom_range(61, 65));  // ten steps: offsets 0, 20, 25 .. 60
    do_reset();
    add_seg(2'b01, hold, 1'b0);
    add_seg(2'b11, 25, 1'b0);
    run_pattern();
    w0n = 0;
    w1n = 0;
    for (int n = 0; n < oc0.size(); n++) begin
      model_at(m0, 1, 0, hold, n, 1'b0, e0, x0);
      model_at(m1, 1, 0, hold, n, 1'b1, e1, x1);
      w0n += int'(ow0[n]);
      w1n += int'(ow1[n]);
      n_cmp += 2;
      if (oc0[n] !== e0 || ol0[n] !== e0 || ow0[n] !== x0) begin
        n_bad++;
        $display("FAIL hold_sat0 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc0[n], ol0[n], ow0[n], e0, x0);
      end
      if (oc1[n] !== e1 || ol1[n] !== e1 || ow1[n] !== x1) begin
        n_bad++;
        $display("FAIL hold_sat1 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc1[n], ol1[n], ow1[n], e1, x1);
      end
    end
    n_cmp++;
    if (w0n != 1 || w1n != 1 || oc0[oc0.size() - 1] != 0 || oc1[oc1.size() - 1] != 9) begin
      n_bad++;
      $display("FAIL hold_summary: wraps0=%0d wraps1=%0d end0=%0d end1=%0d, want 1 1 0 9",
               w0n, w1n, oc0[oc0.size() - 1], oc1[oc1.size() - 1]);
    end
    m0 = e0;
    m1 = e1;
  endtask

  task automatic test_down_wrap();
    int e0, e1; bit x0, x1;
    int hold = DEB + 2 + int'($urandom % 4);
    do_reset();
    add_seg(2'b10, hold, 1'b0);
    add_seg(2'b11, 25, 1'b0);
    run_pattern();
    for (int n = 0; n < oc0.size(); n++) begin
      model_at(m0, -1, 0, hold, n, 1'b0, e0, x0);
      model_at(m1, -1, 0, hold, n, 1'b1, e1, x1);
      n_cmp += 2;
      if (oc0[n] !== e0 || ol0[n] !== e0 || ow0[n] !== x0) begin
        n_bad++;
        $display("FAIL down_sat0 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc0[n], ol0[n], ow0[n], e0, x0);
      end
      if (oc1[n] !== e1 || ol1[n] !== e1 || ow1[n] !== x1) begin
        n_bad++;
        $display("FAIL down_sat1 n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                 n, oc1[n], ol1[n], ow1[n], e1, x1);
      end
    end
    m0 = e0;
    m1 = e1;
  endtask

  task automatic test_random_presses();
    int e0, e1, dir, hold; bit x0, x1;
    for (int it = 0; it < 6; it++) begin
      dir  = ($urandom % 2) ? 1 : -1;
      hold = int'($urandom_range(DEB, 70));
      add_seg((dir > 0) ? 2'b01 : 2'b10, hold, 1'b0);
      add_seg(2'b11, int'($urandom_range(DEB + 4, 20)), 1'b0);
      run_pattern();
      for (int n = 0; n < oc0.size(); n++) begin
        model_at(m0, dir, 0, hold, n, 1'b0, e0, x0);
        model_at(m1, dir, 0, hold, n, 1'b1, e1, x1);
        n_cmp += 2;
        if (oc0[n] !== e0 || ol0[n] !== e0 || ow0[n] !== x0) begin
          n_bad++;
          $display("FAIL random_sat0 it=%0d n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                   it, n, oc0[n], ol0[n], ow0[n], e0, x0);
        end
        if (oc1[n] !== e1 || ol1[n] !== e1 || ow1[n] !== x1) begin
          n_bad++;
          $display("FAIL random_sat1 it=%0d n=%0d: cnt=%0d led=%0d wrap=%0b, want cnt=%0d wrap=%0b",
                   it, n, oc1[n], ol1[n], ow1[n], e1, x1);
        end
      end
      m0 = e0;
      m1 = e1;
    end
  endtask

  task automatic test_both_buttons();
    int hold = int'($urandom_range(DEB, 50));
    add_seg(2'b00, hold, 1'b0);
    add_seg(2'b11, 20, 1'b0);
    run_pattern();
    for (int n = 0; n < oc0.size(); n++) begin
      n_cmp++;
      if (oc0[n] !== m0 || ow0[n] !== 1'b0 || oc1[n] !== m1 || ow1[n] !== 1'b0) begin
        n_bad++;
        $display("FAIL both_buttons n=%0d: cnt0=%0d wrap0=%0b cnt1=%0d wrap1=%0b, want %0d 0 %0d 0",
                 n, oc0[n], ow0[n], oc1[n], ow1[n], m0, m1);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int e0; bit x0;
    int s2 = 120;
    do_reset();
    // Up held low for indices 0..99; reset lands on edge 56, where the t=50 repeat would fall
    add_seg(2'b01, 56, 1'b0);
    add_seg(2'b01, 1, 1'b1);
    add_seg(2'b01, 43, 1'b0);
    add_seg(2'b11, 20, 1'b0);
    add_seg(2'b01, DEB + 2, 1'b0);
    add_seg(2'b11, 20, 1'b0);
    run_pattern();
    n_cmp++;
    if (oc0[55] !== 7 || oc1[55] !== 7) begin
      n_bad++;
      $display("FAIL rst_mid_before: cnt0=%0d cnt1=%0d, want 7", oc0[55], oc1[55]);
    end
    for (int n = 0; n < oc0.size(); n++) begin
      if (n < 56) model_at(0, 1, 0, 100, n, 1'b0, e0, x0);
      else        model_at(0, 1, s2, DEB + 2, n, 1'b0, e0, x0);
      n_cmp++;
      if (oc0[n] !== e0 || ow0[n] !== x0 || oc1[n] !== e0 || ow1[n] !== x0) begin
        n_bad++;
        $display("FAIL rst_mid n=%0d: cnt0=%0d wrap0=%0b cnt1=%0d wrap1=%0b, want cnt=%0d wrap=%0b",
                 n, oc0[n], ow0[n], oc1[n], ow1[n], e0, x0);
      end
    end
    m0 = e0;
    m1 = e0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_repeat();
    test_down_wrap();
    test_random_presses();
    test_both_buttons();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
